// File: rtl/poc_ctrl.sv
// poc_ctrl: processor-side status/data registers plus the printer strobe engine.
// Optional STROBE abort with sticky SR6 error is enabled by defining POC_TIMEOUT_EN.
module poc_ctrl #(
    parameter int unsigned SETUP_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rw,
    input  logic [2:0] addr,
    input  logic       reg_in,
    input  logic [7:0] data_in,
    output logic       reg_out,
    output logic       irq,
    output logic [7:0] pd,
    output logic       tr,
    input  logic       rdy
);
    // state        | meaning
    // ST_IDLE      | no transfer in flight, SR7=1, waiting for a start write
    // ST_WAIT_RDY  | pd latched, waiting for the printer to report ready
    // ST_SETUP     | pd settling before the strobe, cnt counts down
    // ST_STROBE    | tr high, waiting for the printer to accept (rdy=0)
    // ST_WAIT_DONE | tr low, waiting for the printer to finish (rdy=1)
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RDY  = 3'd1,
        ST_SETUP     = 3'd2,
        ST_STROBE    = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    localparam logic [19:0] SETUP_LOAD   = 20'(SETUP_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LOAD = 20'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        sr0_q, sr0_d;
    logic        sr6_q, sr6_d;
    logic        sr7_q, sr7_d;
    logic [7:0]  br_q, br_d;
    logic [7:0]  pd_q, pd_d;
    logic        tr_q, tr_d;
    logic        irq_q, irq_d;
    logic        reg_out_q, reg_out_d;
    logic        start;
    logic        timeout;

    // SR7=1 only while idle, so the start test needs no state qualifier.
    assign start = rw && (addr == 3'd7) && !reg_in && sr7_q;

`ifdef POC_TIMEOUT_EN
    assign timeout = (state_q == ST_STROBE) && rdy && (cnt_q == '0);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sr0_q     <= 1'b0;
            sr6_q     <= 1'b0;
            sr7_q     <= 1'b1;
            br_q      <= '0;
            pd_q      <= '0;
            tr_q      <= 1'b0;
            irq_q     <= 1'b1;
            reg_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr0_q     <= sr0_d;
            sr6_q     <= sr6_d;
            sr7_q     <= sr7_d;
            br_q      <= br_d;
            pd_q      <= pd_d;
            tr_q      <= tr_d;
            irq_q     <= irq_d;
            reg_out_q <= reg_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_WAIT_RDY;
            ST_WAIT_RDY:  if (rdy) state_d = ST_SETUP;
            ST_SETUP:     if (cnt_q == '0) state_d = ST_STROBE;
            ST_STROBE: begin
                if (!rdy)         state_d = ST_WAIT_DONE;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_WAIT_DONE: if (rdy) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        sr0_d = sr0_q;
        sr6_d = sr6_q;
        sr7_d = sr7_q;
        br_d  = br_q;
        pd_d  = pd_q;
        tr_d  = tr_q;

        if (rw && (addr == 3'd0)) sr0_d = reg_in;
        if (rw && (addr == 3'd1)) br_d  = data_in;
`ifdef POC_TIMEOUT_EN
        if (rw && (addr == 3'd6) && !reg_in) sr6_d = 1'b0;
        if (timeout) sr6_d = 1'b1;
`else
        sr6_d = 1'b0;
`endif
        if (start) begin
            sr7_d = 1'b0;
            pd_d  = br_q;
        end

        case (state_q)
            ST_WAIT_RDY: if (rdy) cnt_d = SETUP_LOAD;
            ST_SETUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 20'd1;
                end else begin
                    tr_d  = 1'b1;
                    cnt_d = TIMEOUT_LOAD;
                end
            end
            ST_STROBE: begin
                if (!rdy) begin
                    tr_d = 1'b0;
                end else if (timeout) begin
                    tr_d  = 1'b0;
                    sr7_d = 1'b1;
                end else if (cnt_q != '0) begin
`ifdef POC_TIMEOUT_EN
                    cnt_d = cnt_q - 20'd1;
`endif
                end
            end
            ST_WAIT_DONE: if (rdy) sr7_d = 1'b1;
            default: ;
        endcase

        case (addr)
            3'd0:    reg_out_d = sr0_q;
            3'd6:    reg_out_d = sr6_q;
            3'd7:    reg_out_d = sr7_q;
            default: reg_out_d = 1'b0;
        endcase
        irq_d = ~(sr0_q & sr7_q);
    end

    assign reg_out = reg_out_q;
    assign irq     = irq_q;
    assign pd      = pd_q;
    assign tr      = tr_q;
endmodule

// File: tb/tb_poc_ctrl.sv
// Scoreboard bench for poc_ctrl: a transfer-level reference model predicts register,
// irq, pd and tr values per cycle; a monitor process compares them against the DUT.
module tb_poc_ctrl;
    localparam int SETUP_CYCLES = 4;
`ifdef POC_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 100;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TIMEOUT_CYCLES = 50000;
    localparam bit TO_EN = 1'b0;
`endif
    localparam int NEVER = 1 << 20;
    localparam int BIG   = 1 << 30;
    localparam int K_REG = 0;
    localparam int K_IRQ = 1;
    localparam int K_TR  = 2;
    localparam int K_PD  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rw = 1'b0;
    logic [2:0] addr = 3'd0;
    logic       reg_in = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       rdy = 1'b1;
    logic       reg_out, irq, tr;
    logic [7:0] pd;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct { int due; int kind; logic [7:0] exp; } chk_t;
    typedef struct { int rise; int fall; logic [7:0] data; } xfer_t;
    typedef struct { int dr; int hold; } prn_t;
    chk_t  sbq[$];
    xfer_t xq[$];
    prn_t  pq[$];

    poc_ctrl #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rw     (rw),
        .addr   (addr),
        .reg_in (reg_in),
        .data_in(data_in),
        .reg_out(reg_out),
        .irq    (irq),
        .pd     (pd),
        .tr     (tr),
        .rdy    (rdy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: register contents plus the schedule of the latest transfer.
    bit         m_sr0;
    logic [7:0] m_br, m_pd, m_pd_prev;
    int m_start, m_rise, m_fall, m_done, m_s6set, m_s6clr;

    function automatic void model_reset();
        m_sr0 = 1'b0; m_br = 8'd0; m_pd = 8'd0; m_pd_prev = 8'd0;
        m_start = -1000; m_rise = -1000; m_fall = -1000; m_done = -1000;
        m_s6set = BIG; m_s6clr = BIG;
    endfunction

    function automatic bit sr7_at(int n);
        return !(n >= m_start && n < m_done);
    endfunction
    function automatic bit tr_at(int n);
        return (n >= m_rise) && (n < m_fall);
    endfunction
    function automatic logic [7:0] pd_at(int n);
        return (n >= m_start) ? m_pd : m_pd_prev;
    endfunction
    function automatic bit sr6_at(int n);
        return (n >= m_s6set) && (n < m_s6clr);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: timed expectations every cycle, transfer records on tr edges.
    logic  tr_prev = 1'b0;
    xfer_t cur;
    bit    cur_v = 1'b0;
    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                case (sbq[i].kind)
                    K_REG:   check("reg_out", 32'(reg_out), 32'(sbq[i].exp[0]));
                    K_IRQ:   check("irq", 32'(irq), 32'(sbq[i].exp[0]));
                    K_TR:    check("tr", 32'(tr), 32'(sbq[i].exp[0]));
                    default: check("pd", 32'(pd), 32'(sbq[i].exp));
                endcase
                sbq.delete(i);
            end
        end
        if (tr === 1'b1 && tr_prev === 1'b0) begin
            if (xq.size() == 0) begin
                total++; bad++;
                $display("FAIL xfer_unexpected at cyc %0d: got strobe want none", cyc);
            end else begin
                cur = xq.pop_front();
                cur_v = 1'b1;
                check("xfer_rise_cyc", 32'(cyc), 32'(cur.rise));
                check("xfer_rise_pd", 32'(pd), 32'(cur.data));
            end
        end
        if (tr === 1'b0 && tr_prev === 1'b1 && cur_v) begin
            check("xfer_fall_cyc", 32'(cyc), 32'(cur.fall));
            check("xfer_fall_pd", 32'(pd), 32'(cur.data));
            cur_v = 1'b0;
        end
        tr_prev = tr;
    end

    // Printer: accepts dr cycles after the strobe, stays busy for hold cycles.
    initial begin
        prn_t p;
        forever begin
            @(posedge tr);
            if (pq.size() != 0) p = pq.pop_front();
            else p = '{2, 10};
            if (p.dr < NEVER) begin
                repeat (p.dr) @(posedge clk);
                #1 rdy = 1'b0;
                repeat (p.hold) @(posedge clk);
                #1 rdy = 1'b1;
            end
        end
    end

    task automatic do_cycle(bit w, logic [2:0] a, bit ri, logic [7:0] d, int dr, int hold);
        int n;
        bit ro;
        n = cyc;
        rw = w; addr = a; reg_in = ri; data_in = d;
        case (a)
            3'd0:    ro = m_sr0;
            3'd6:    ro = sr6_at(n);
            3'd7:    ro = sr7_at(n);
            default: ro = 1'b0;
        endcase
        sbq.push_back('{n + 1, K_REG, 8'(ro)});
        sbq.push_back('{n + 1, K_IRQ, 8'(~(m_sr0 & sr7_at(n)))});
        if (w) begin
            case (a)
                3'd0: m_sr0 = ri;
                3'd1: m_br = d;
                3'd6: if (!ri && (n + 1) > m_s6set && (n + 1) < m_s6clr) m_s6clr = n + 1;
                3'd7: if (!ri && sr7_at(n)) begin
                    m_pd_prev = pd_at(n);
                    m_pd = m_br;
                    m_start = n + 1;
                    m_rise = n + 2 + SETUP_CYCLES;
                    if (TO_EN && dr >= TIMEOUT_CYCLES) begin
                        m_fall = m_rise + TIMEOUT_CYCLES;
                        m_done = m_fall;
                        m_s6set = m_fall;
                        m_s6clr = BIG;
                    end else begin
                        m_fall = m_rise + dr + 1;
                        m_done = m_fall + hold;
                    end
                    xq.push_back('{m_rise, m_fall, m_pd});
                    pq.push_back('{dr, hold});
                end
                default: ;
            endcase
        end
        sbq.push_back('{n + 1, K_TR, 8'(tr_at(n + 1))});
        sbq.push_back('{n + 1, K_PD, pd_at(n + 1)});
        @(posedge clk);
        #1;
    endtask

    task automatic rd(logic [2:0] a);
        do_cycle(1'b0, a, 1'b0, 8'd0, 0, 0);
    endtask

    task automatic wait_idle(int extra);
        while (!sr7_at(cyc)) rd(3'd7);
        repeat (extra) rd(3'd7);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cyc %0d: got no finish want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        model_reset();
        #5 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_tr", 32'(tr), 32'd0);
        check("reset_irq", 32'(irq), 32'd1);
        check("reset_pd", 32'(pd), 32'd0);
        check("reset_reg_out", 32'(reg_out), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd(3'd7);
        rd(3'd0);
        rd(3'd6);

        // Polling transfer with busy-time writes that must not disturb it.
        do_cycle(1'b1, 3'd1, 1'b0, 8'h48, 0, 0);
        do_cycle(1'b1, 3'd7, 1'b0, 8'h00, 2, 10);
        rd(3'd7);
        do_cycle(1'b1, 3'd1, 1'b0, 8'h55, 0, 0);
        do_cycle(1'b1, 3'd7, 1'b1, 8'h00, 0, 0);
        do_cycle(1'b1, 3'd7, 1'b0, 8'h00, 1, 1);
        wait_idle(3);

        // Interrupt mode.
        do_cycle(1'b1, 3'd0, 1'b1, 8'h00, 0, 0);
        rd(3'd0);
        rd(3'd7);
        do_cycle(1'b1, 3'd7, 1'b0, 8'h00, 3, 4);
        wait_idle(3);

        repeat (1500) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: rd(3'($urandom_range(0, 7)));
                4: do_cycle(1'b1, 3'd0, 1'($urandom_range(0, 1)), 8'h00, 0, 0);
                5: do_cycle(1'b1, 3'd1, 1'b0, 8'($urandom_range(0, 255)), 0, 0);
                6, 7: do_cycle(1'b1, 3'd7, 1'b0, 8'h00, $urandom_range(1, 4), $urandom_range(1, 12));
                8: do_cycle(1'b1, 3'd7, 1'b1, 8'h00, 0, 0);
                default: do_cycle(1'b1, 3'($urandom_range(2, 6)), 1'($urandom_range(0, 1)), 8'h00, 0, 0);
            endcase
        end
        wait_idle(2);

        // Printer never accepts: only the timeout build can leave STROBE.
        if (TO_EN) begin
            do_cycle(1'b1, 3'd1, 1'b0, 8'hA5, 0, 0);
            do_cycle(1'b1, 3'd7, 1'b0, 8'h00, NEVER, 0);
            wait_idle(2);
            rd(3'd6);
            do_cycle(1'b1, 3'd6, 1'b1, 8'h00, 0, 0);
            rd(3'd6);
            do_cycle(1'b1, 3'd6, 1'b0, 8'h00, 0, 0);
            rd(3'd6);
            rd(3'd6);
        end

        // Reset while the strobe is high.
        do_cycle(1'b1, 3'd0, 1'b1, 8'h00, 0, 0);
        do_cycle(1'b1, 3'd1, 1'b0, 8'h3C, 0, 0);
        do_cycle(1'b1, 3'd7, 1'b0, 8'h00, 30, 5);
        while (cyc < m_rise + 3) rd(3'd7);
        rst_n = 1'b0;
        #1;
        check("midreset_tr", 32'(tr), 32'd0);
        check("midreset_pd", 32'(pd), 32'd0);
        check("midreset_irq", 32'(irq), 32'd1);
        check("midreset_reg_out", 32'(reg_out), 32'd0);
        sbq.delete();
        xq.delete();
        pq.delete();
        cur_v = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd(3'd7);
        rd(3'd0);
        rd(3'd6);
        rd(3'd7);
        @(negedge clk);
        #1;
        if (sbq.size() != 0 || xq.size() != 0) begin
            total++; bad++;
            $display("FAIL leftover_expectations: got %0d/%0d pending want 0/0", sbq.size(), xq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
